// File: rtl/b_uart_pkg.sv
// Shared types and constants for the b_uart transceiver.
package b_uart_pkg;

  localparam int unsigned AccW = 33;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

endpackage

// File: rtl/b_uart_if.sv
// CPU-side strobe/data bundle of the b_uart transceiver.
interface b_uart_if;

  logic       rd;
  logic       wr;
  logic [7:0] tx_data;
  logic       valid;
  logic       busy;
  logic [7:0] rx_data;

  modport master (output rd, wr, tx_data, input valid, busy, rx_data);
  modport slave  (input rd, wr, tx_data, output valid, busy, rx_data);

endinterface

// File: rtl/b_uart_baudgen.sv
// Phase-accumulator bit-rate generator: ticks at an average rate of baud per ClkFreq cycles.
module b_uart_baudgen
  import b_uart_pkg::*;
#(
  parameter int unsigned ClkFreq = 40_000_000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [31:0] baud,
  input  logic        clear,
  input  logic        preload,
  output logic        tick
);

  localparam logic [AccW-1:0] Limit = AccW'(ClkFreq);
  localparam logic [AccW-1:0] Half  = AccW'(ClkFreq / 2);

  logic [AccW-1:0] acc_q, acc_d, sum;

  always_comb begin
    sum  = acc_q + AccW'(baud);
    tick = (sum >= Limit);
    if (clear) begin
      acc_d = '0;
    end else if (preload) begin
      acc_d = Half;
    end else if (tick) begin
      acc_d = sum - Limit;
    end else begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/b_uart.sv
// 8N1 LSB-first UART with independent TX and RX paths and runtime baud rate.
module b_uart
  import b_uart_pkg::*;
#(
  parameter int unsigned CLKFREQ = 40_000_000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [31:0] baud,
  input  logic        rx,
  output logic        tx,
  b_uart_if.slave     bus
);

  // ---------------- Transmitter ----------------
  uart_state_e tx_state_q, tx_state_d;
  logic [7:0]  tx_shift_q;
  logic [2:0]  tx_cnt_q;
  logic        tx_tick;
  logic        tx_start;

  assign tx_start = (tx_state_q == IDLE) && bus.wr;

  b_uart_baudgen #(
    .ClkFreq (CLKFREQ)
  ) u_tx_baud (
    .clk     (clk),
    .resetq  (resetq),
    .baud    (baud),
    .clear   (tx_start),
    .preload (1'b0),
    .tick    (tx_tick)
  );

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_q <= IDLE;
    end else begin
      tx_state_q <= tx_state_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      IDLE:  if (bus.wr) tx_state_d = START;
      START: if (tx_tick) tx_state_d = DATA;
      DATA:  if (tx_tick && (tx_cnt_q == 3'd7)) tx_state_d = STOP;
      STOP:  if (tx_tick) tx_state_d = IDLE;
      default: tx_state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (tx_state_q != IDLE);
    unique case (tx_state_q)
      START:   tx = 1'b0;
      DATA:    tx = tx_shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
    end else if (tx_start) begin
      tx_shift_q <= bus.tx_data;
      tx_cnt_q   <= '0;
    end else if ((tx_state_q == DATA) && tx_tick) begin
      tx_shift_q <= {1'b0, tx_shift_q[7:1]};
      tx_cnt_q   <= tx_cnt_q + 3'd1;
    end
  end

  // ---------------- Receiver ----------------
  uart_state_e rx_state_q, rx_state_d;
  logic [7:0]  rx_shift_q;
  logic [2:0]  rx_cnt_q;
  logic [7:0]  rx_data_q;
  logic        valid_q;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        rx_fall, rx_arm, rx_tick, rx_done;

  // Sync flops reset high so an idle line never looks like a start edge.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q && !rx_sync_q;
  assign rx_arm  = (rx_state_q == IDLE) && rx_fall;
  assign rx_done = (rx_state_q == STOP) && rx_tick && rx_sync_q;

  // Preload to half a bit so every tick lands mid-bit.
  b_uart_baudgen #(
    .ClkFreq (CLKFREQ)
  ) u_rx_baud (
    .clk     (clk),
    .resetq  (resetq),
    .baud    (baud),
    .clear   (1'b0),
    .preload (rx_arm),
    .tick    (rx_tick)
  );

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_state_q <= IDLE;
    end else begin
      rx_state_q <= rx_state_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      IDLE:  if (rx_fall) rx_state_d = START;
      START: if (rx_tick) rx_state_d = rx_sync_q ? IDLE : DATA;
      DATA:  if (rx_tick && (rx_cnt_q == 3'd7)) rx_state_d = STOP;
      STOP:  if (rx_tick) rx_state_d = IDLE;
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.valid   = valid_q;
    bus.rx_data = rx_data_q;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
    end else if (rx_arm) begin
      rx_cnt_q   <= '0;
    end else if ((rx_state_q == DATA) && rx_tick) begin
      rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
      rx_cnt_q   <= rx_cnt_q + 3'd1;
    end
  end

  // A completing byte takes priority over a simultaneous rd.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_data_q <= '0;
      valid_q   <= 1'b0;
    end else if (rx_done) begin
      rx_data_q <= rx_shift_q;
      valid_q   <= 1'b1;
    end else if (bus.rd) begin
      valid_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_b_uart.sv
// Scoreboard bench for b_uart: random TX/RX bytes checked by line-level monitors.
module tb_b_uart;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic [31:0] baud = 32'd100_000;
  logic        rx = 1'b1;
  logic        tx;

  b_uart_if bus ();

  b_uart #(
    .CLKFREQ (1_000_000)
  ) dut (
    .clk    (clk),
    .resetq (resetq),
    .baud   (baud),
    .rx     (rx),
    .tx     (tx),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  bit         tx_mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Expected TX frame: start 0, 8 data bits LSB first, stop 1, 10 cycles each.
  initial begin
    logic       tx_prev;
    logic [9:0] bits;
    int         busy_cnt;
    logic [7:0] e;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mon_en && resetq && tx_prev && !tx) begin
        bits = '0;
        busy_cnt = 0;
        for (int k = 0; k < 300; k++) begin
          if (!bus.busy) break;
          if ((k % 10 == 5) && (k < 100)) bits[k/10] = tx;
          busy_cnt++;
          @(negedge clk);
        end
        if (exp_tx.size() == 0) begin
          fail_now("tx_unexpected_frame", "frame seen with nothing queued");
        end else begin
          e = exp_tx.pop_front();
          check("tx_start_bit", 32'(bits[0]), 32'd0);
          check("tx_byte", 32'(bits[8:1]), 32'(e));
          check("tx_stop_bit", 32'(bits[9]), 32'd1);
          check("tx_busy_len", 32'(busy_cnt), 32'd100);
        end
      end
      tx_prev = tx;
    end
  end

  // A received byte shows as valid rising or rx_data changing while valid.
  initial begin
    logic       pv;
    logic [7:0] pd;
    logic [7:0] e;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (bus.valid && (!pv || (bus.rx_data != pd))) begin
        if (exp_rx.size() == 0) begin
          fail_now("rx_unexpected_byte", "byte seen with nothing queued");
        end else begin
          e = exp_rx.pop_front();
          check("rx_byte", 32'(bus.rx_data), 32'(e));
        end
      end
      pv = bus.valid;
      pd = bus.rx_data;
    end
  end

  task automatic send_tx(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) fail_now("tx_busy_timeout", "busy never dropped");
    bus.wr = 1'b1;
    bus.tx_data = b;
    exp_tx.push_back(b);
    @(negedge clk);
    bus.wr = 1'b0;
    bus.tx_data = 8'($urandom);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (stop) exp_rx.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic pulse_rd();
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  initial begin
    #200_000;
    fail_now("watchdog", "simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] cb;
    logic [9:0] f;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.tx_data = '0;
    resetq = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_rx_data", 32'(bus.rx_data), 32'd0);
    resetq = 1'b1;
    @(negedge clk);

    fork
      begin : tx_side
        send_tx(8'hA5);
        repeat (29) @(negedge clk);
        bus.wr = 1'b1;
        bus.tx_data = 8'hFF;
        @(negedge clk);
        bus.wr = 1'b0;
        repeat (6) send_tx(8'($urandom));
      end
      begin : rx_side
        send_rx(8'h3C, 1'b1);
        pulse_rd();
        check("rd_clears_valid", 32'(bus.valid), 32'd0);
        // Short glitch must not produce a byte.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_valid", 32'(bus.valid), 32'd0);
        // Framing error: stop bit low.
        send_rx(8'h55, 1'b0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("framing_no_valid", 32'(bus.valid), 32'd0);
        check("framing_rx_data_kept", 32'(bus.rx_data), 32'h3C);
        repeat (6) begin
          send_rx(8'($urandom), 1'b1);
          pulse_rd();
          check("rd_clears_valid_rand", 32'(bus.valid), 32'd0);
          repeat ($urandom_range(0, 7)) @(negedge clk);
        end
        // Overrun then a byte completing together with rd.
        send_rx(8'h11, 1'b1);
        send_rx(8'h33, 1'b1);
        check("overrun_valid", 32'(bus.valid), 32'd1);
        check("overrun_data", 32'(bus.rx_data), 32'h33);
        cb = 8'h22;
        f = {1'b1, cb, 1'b0};
        exp_rx.push_back(cb);
        for (int i = 0; i < 9; i++) begin
          rx = f[i];
          repeat (10) @(negedge clk);
        end
        rx = 1'b1;
        bus.rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (bus.rd && (bus.rx_data == cb)) bus.rd = 1'b0;
        end
        bus.rd = 1'b0;
        check("collision_valid", 32'(bus.valid), 32'd1);
        check("collision_data", 32'(bus.rx_data), 32'h22);
      end
    join

    repeat (20) @(negedge clk);
    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);

    // Reset in the middle of a frame, with an unread byte pending.
    tx_mon_en = 1'b0;
    bus.wr = 1'b1;
    bus.tx_data = 8'hC3;
    @(negedge clk);
    bus.wr = 1'b0;
    repeat (24) @(negedge clk);
    #2 resetq = 1'b0;
    #1;
    check("midreset_tx", 32'(tx), 32'd1);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_valid", 32'(bus.valid), 32'd0);
    @(negedge clk);
    resetq = 1'b1;
    repeat (5) @(negedge clk);
    tx_mon_en = 1'b1;
    @(negedge clk);
    send_tx(8'h00);
    repeat (110) @(negedge clk);
    check("tx_after_reset_done", 32'(exp_tx.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
